program_sink: RTL

//  Receiving end of the graphic program-write interface (program_x/y/data/write) driven by the copy engine.

---
 rtl/program_sink.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/program_sink.sv
// Receiving end of the copy engine's pixel-write interface: maps (x,y) to a linear
// SRAM address, buffers writes in a FIFO and drains them whenever scan-out leaves the SRAM free.
module program_sink #(
    parameter int DEPTH        = 16,
    parameter int WRITE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  program_x,
    input  logic [9:0]  program_y,
    input  logic [15:0] program_data,
    input  logic        program_write,
    input  logic        frame_sel,
    input  logic        clear_err,
    input  logic        sram_busy,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_we_n,
    output logic        fifo_empty,
    output logic [6:0]  level,
    output logic        overflow,
    output logic        range_err
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [6:0] DEPTH_L = 7'(DEPTH);
    localparam logic [1:0] WC_LAST = 2'(WRITE_CYCLES - 1);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t        state_reg;
    logic [1:0]    wcnt_reg;
    logic          s1_valid_reg;
    logic [19:0]   s1_addr_reg;
    logic [15:0]   s1_data_reg;
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [6:0]    level_reg;
    logic          overflow_reg;
    logic          range_err_reg;

    logic          in_range;
    logic [18:0]   pix;
    logic          last_cycle;
    logic          pop;
    logic          push;
    logic          drop;

    always_comb begin
        in_range   = (program_x < 10'd640) && (program_y < 10'd480);
        // y*640 + x as two shifts and an add
        pix        = ({9'd0, program_y} << 9) + ({9'd0, program_y} << 7) + {9'd0, program_x};
        last_cycle = (state_reg == S_WRITE) && (wcnt_reg == WC_LAST);
        pop        = !sram_busy && (level_reg != 7'd0) && ((state_reg == S_IDLE) || last_cycle);
        push       = s1_valid_reg && ((level_reg != DEPTH_L) || pop);
        drop       = s1_valid_reg && !push;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_addr_reg  <= '0;
            s1_data_reg  <= '0;
        end else begin
            s1_valid_reg <= program_write && in_range;
            if (program_write) begin
                s1_addr_reg <= {frame_sel, pix};
                s1_data_reg <= program_data;
            end
        end
    end

    // A new error in the same cycle as clear_err keeps the flag set
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            range_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (program_write && !in_range)
                range_err_reg <= 1'b1;
            else if (clear_err)
                range_err_reg <= 1'b0;

            if (drop)
                overflow_reg <= 1'b1;
            else if (clear_err)
                overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {s1_addr_reg, s1_data_reg};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 7'd1;
                2'b01:   level_reg <= level_reg - 7'd1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Head word is read straight into the SRAM output registers on pop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= S_IDLE;
            wcnt_reg   <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pop) begin
                        {sram_addr, sram_wdata} <= mem[rd_ptr_reg];
                        sram_we_n <= 1'b0;
                        wcnt_reg  <= '0;
                        state_reg <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!last_cycle) begin
                        wcnt_reg <= wcnt_reg + 2'd1;
                    end else if (pop) begin
                        {sram_addr, sram_wdata} <= mem[rd_ptr_reg];
                        wcnt_reg <= '0;
                    end else begin
                        sram_we_n <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    sram_we_n <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_empty = (level_reg == 7'd0) && !s1_valid_reg && (state_reg == S_IDLE);
    assign level      = level_reg;
    assign overflow   = overflow_reg;
    assign range_err  = range_err_reg;

endmodule
